alu_acc_bank: RTL and testbench
===============================

// Module: alu_acc_bank
// PURPOSE
//  Multi-accumulator successor to the single-accumulator ALU. It holds NUM_ACC independent WIDTH-bit accumulators.
//  Operations arrive over a valid/ready handshake, and a multi-cycle shift-add MUL is added.
//  Each operation updates one selected accumulator from operand `in`, and flags are registered with the result.
//  The block sits between the instruction sequencer and the datapath register read ports.
// PARAMETERS
//  WIDTH    8  accumulator/operand width in bits (>=2)
//  NUM_ACC  4  number of accumulators (power of 2, >=2); localparam SEL_W = $clog2(NUM_ACC)
// PORTS
//  clk       in   1        clock; all state changes on posedge
//  rst       in   1        synchronous, active-high reset
//  in_valid  in   1        op/acc_sel/in valid this cycle
//  in_ready  out  1        block can accept an op this cycle
//  op        in   4        opcode (see BEHAVIOUR)
//  acc_sel   in   SEL_W    target accumulator index
//  in        in   WIDTH    operand
//  rd_sel    in   SEL_W    read-port index
//  rd_data   out  WIDTH    combinational read: acc[rd_sel]
//  flags     out  4        {carry, zero, overflow, sign} of last completed op
//  busy      out  1        MUL in progress (== ~in_ready)
//  done      out  1        one-cycle pulse: an op completed at the previous edge
// BEHAVIOUR
//  Reset:
//  - At rst: all acc = 0, flags = 0, done = 0, busy = 0, in_ready = 1, FSM -> IDLE.
//  - rst wins over every other input and aborts a MUL mid-flight; no done is produced for the aborted op.
//  Accept and FSM:
//  - Accept = in_valid & in_ready at posedge. in_valid while busy is ignored, not queued.
//  - FSM states: IDLE (in_ready = 1) and MUL_RUN (in_ready = 0).
//  - IDLE -> MUL_RUN on accept of MUL. MUL_RUN -> IDLE after WIDTH iterations.
//  Latency:
//  - Single-cycle ops accepted at edge k write acc[acc_sel] and flags at edge k; done = 1 for the cycle after edge k.
//  - Back-to-back accepts are allowed every cycle.
//  - MUL accepted at edge k latches acc_sel, multiplicand and multiplier, then runs one shift-add step per cycle.
//  - MUL writes acc and flags at edge k+WIDTH; done = 1 for the cycle after that edge.
//  - in_ready returns to 1 in the same cycle that done = 1.
//  Opcodes (A = acc[acc_sel], B = in, R = result, width WIDTH, mod 2^WIDTH):
//   0 HOLD R=A | 1 CLEAR R=0 | 2 ADD R=A+B | 3 SUB R=A-B | 4 AND | 5 NEG R=-A
//   6 NOT R=~A | 7 XOR | 8 OR | 9 LOAD R=B | 10 SHL R=A<<1 | 11 SHR arithmetic R=A>>>1
//   12 MUL R=(A*B) low WIDTH bits, unsigned | 13-15 reserved, behave as HOLD
//  Flags (all four rewritten on every completed op):
//  - sign = R[WIDTH-1]; zero = (R == 0).
//  - ADD: carry = bit WIDTH of A+B; overflow = (A,B same sign) & (R sign != A sign).
//  - SUB: carry = borrow (A < B unsigned); overflow = (A,B sign differ) & (R sign != A sign).
//  - SHL: carry = A[WIDTH-1]; overflow = A[WIDTH-1] ^ A[WIDTH-2].
//  - SHR: carry = A[0]; overflow = 0.
//  - MUL: carry = (upper WIDTH bits of the full product != 0); overflow = 0.
//  - All other ops: carry = 0, overflow = 0.
//  Write scope:
//  - Only acc[acc_sel] is written; the other accumulators keep their values.
//  - rd_data reflects a write from the cycle after the writing edge.
//  - A single-cycle op and a MUL never complete in the same cycle, because accept is blocked while busy.
// TESTING (WIDTH=8, NUM_ACC=4)
//  1. rst; LOAD 0x7F->acc0; ADD 0x01 -> acc0=0x80, flags={0,0,1,1}, done pulses each op.
//  2. LOAD 0x00->acc1; SUB 0x01 -> acc1=0xFF, flags={1,0,0,1}; rd_sel=0 still reads 0x80.
//  3. LOAD 0x0D->acc2; MUL 0x0B -> in_ready low 8 cycles, then acc2=0x8F, flags={0,0,0,1}, one done pulse.
//  4. LOAD 0x10->acc3; MUL 0x10 -> acc3=0x00, flags={1,1,0,0}; in_valid pulses during busy change nothing.
//  5. Start MUL, assert rst on 3rd busy cycle -> all acc 0, flags 0, in_ready=1 next cycle, no done.
//  6. LOAD 0x81; SHL -> 0x02, flags={1,0,1,0}; SHR on 0x81 -> 0xC0, carry=1; op 13 -> acc unchanged, done pulses.

Source files
------------

// File: rtl/alu_acc_bank.sv
// -----------------------------------------------------------------------------
// alu_acc_bank
//   Bank of NUM_ACC independent WIDTH-bit accumulators driven by one ALU.
//   Operations are accepted over a valid/ready handshake. Single-cycle ops
//   update the selected accumulator and the flags at the accepting edge. MUL
//   uses an unsigned shift-add multiplier: one step per cycle, WIDTH steps.
//
// Ports
//   clk       in   clock, all state changes on posedge
//   rst       in   synchronous active-high reset (aborts a running MUL)
//   in_valid  in   op/acc_sel/in are valid this cycle
//   in_ready  out  an op can be accepted this cycle (low while MUL runs)
//   op        in   opcode
//   acc_sel   in   target accumulator index
//   in        in   operand B
//   rd_sel    in   read-port index
//   rd_data   out  combinational read of acc[rd_sel]
//   flags     out  {carry, zero, overflow, sign} of the last completed op
//   busy      out  MUL in progress (always ~in_ready)
//   done      out  one-cycle pulse after the edge at which an op completed
// -----------------------------------------------------------------------------
module alu_acc_bank #(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    localparam int SEL_W  = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [SEL_W-1:0] acc_sel,
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_HOLD  = 4'd0;
    localparam logic [3:0] OP_CLEAR = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_NEG   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    state_t                 state_q,   state_d;
    logic [WIDTH-1:0]       acc_q      [NUM_ACC];
    logic [WIDTH-1:0]       acc_d      [NUM_ACC];
    logic [3:0]             flags_q,   flags_d;
    logic                   done_q,    done_d;
    logic [2*WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]     prod_q,    prod_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [SEL_W-1:0]       mul_sel_q, mul_sel_d;

    logic [WIDTH-1:0]       a_s;
    logic [WIDTH-1:0]       res_s;
    logic                   carry_s;
    logic                   ovf_s;
    logic                   accept_s;
    logic [2*WIDTH-1:0]     mul_sum_s;

    assign a_s      = acc_q[acc_sel];
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;
    assign accept_s = in_valid & in_ready;
    assign rd_data  = acc_q[rd_sel];
    assign flags    = flags_q;
    assign done     = done_q;

    // Single-cycle ALU: result plus carry/overflow for the selected accumulator.
    always_comb begin
        res_s   = a_s;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_HOLD:  res_s = a_s;
            OP_CLEAR: res_s = {WIDTH{1'b0}};
            OP_ADD: begin
                {carry_s, res_s} = {1'b0, a_s} + {1'b0, in};
                ovf_s = (a_s[WIDTH-1] == in[WIDTH-1]) & (res_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s   = a_s - in;
                carry_s = (a_s < in);
                ovf_s   = (a_s[WIDTH-1] != in[WIDTH-1]) & (res_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_AND:   res_s = a_s & in;
            OP_NEG:   res_s = {WIDTH{1'b0}} - a_s;
            OP_NOT:   res_s = ~a_s;
            OP_XOR:   res_s = a_s ^ in;
            OP_OR:    res_s = a_s | in;
            OP_LOAD:  res_s = in;
            OP_SHL: begin
                res_s   = {a_s[WIDTH-2:0], 1'b0};
                carry_s = a_s[WIDTH-1];
                ovf_s   = a_s[WIDTH-1] ^ a_s[WIDTH-2];
            end
            OP_SHR: begin
                res_s   = {a_s[WIDTH-1], a_s[WIDTH-1:1]};
                carry_s = a_s[0];
            end
            // MUL goes through the sequential path; reserved codes hold.
            default:  res_s = a_s;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        if (mplier_q[0]) begin
            mul_sum_s = prod_q + mcand_q;
        end else begin
            mul_sum_s = prod_q;
        end
    end

    // Next-state logic for the FSM, accumulators, flags and multiplier datapath.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        mul_sel_d = mul_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op == OP_MUL) begin
                        mcand_d   = {{WIDTH{1'b0}}, a_s};
                        mplier_d  = in;
                        prod_d    = {(2*WIDTH){1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        mul_sel_d = acc_sel;
                        state_d   = ST_MUL_RUN;
                    end else begin
                        acc_d[acc_sel] = res_s;
                        flags_d = {carry_s, (res_s == {WIDTH{1'b0}}), ovf_s, res_s[WIDTH-1]};
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                prod_d   = mul_sum_s;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // The last step's sum is written directly so the result lands
                // exactly WIDTH edges after the accept.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    acc_d[mul_sel_q] = mul_sum_s[WIDTH-1:0];
                    flags_d = {(|mul_sum_s[2*WIDTH-1:WIDTH]),
                               (mul_sum_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                               1'b0,
                               mul_sum_s[WIDTH-1]};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that also aborts a running MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= {WIDTH{1'b0}};
            end
            flags_q   <= 4'd0;
            done_q    <= 1'b0;
            mcand_q   <= {(2*WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            mul_sel_q <= {SEL_W{1'b0}};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            mul_sel_q <= mul_sel_d;
        end
    end

endmodule

// File: tb/tb_alu_acc_bank.sv
// -----------------------------------------------------------------------------
// tb_alu_acc_bank
//   Self-checking bench for alu_acc_bank (WIDTH=8, NUM_ACC=4). Each issued op
//   pushes its expected accumulator value and flags to a scoreboard queue;
//   entries are popped and compared when the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_alu_acc_bank;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] val;
        logic [3:0] flg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [1:0] acc_sel;
    logic [7:0] operand;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    exp_t       sb_q [$];
    logic [7:0] macc [4];
    int         n_checks = 0;
    int         n_fail   = 0;

    alu_acc_bank #(.WIDTH(8), .NUM_ACC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .acc_sel  (acc_sel),
        .in       (operand),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .flags    (flags),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model written with integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, full;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; r = a;
        case (o)
            4'd1:  r = 8'h00;
            4'd2: begin full = ua + ub; r = full[7:0]; c = (full > 255);
                        v = (sa + sb > 127) || (sa + sb < -128); end
            4'd3: begin r = 8'(ua - ub); c = (ua < ub);
                        v = (sa - sb > 127) || (sa - sb < -128); end
            4'd4:  r = a & b;
            4'd5:  r = 8'(0 - ua);
            4'd6:  r = ~a;
            4'd7:  r = a ^ b;
            4'd8:  r = a | b;
            4'd9:  r = b;
            4'd10: begin r = 8'(ua * 2); c = a[7]; v = a[7] ^ a[6]; end
            4'd11: begin r = 8'(sa >>> 1); c = a[0]; end
            4'd12: begin full = ua * ub; r = full[7:0]; c = (full > 255); end
            default: r = a;
        endcase
        f = {c, (r == 8'h00), v, r[7]};
    endfunction

    // Drive one op at a negedge once in_ready is seen; push its expectation.
    task automatic send(input logic [3:0] o, input logic [1:0] s, input logic [7:0] b);
        exp_t e;
        logic [7:0] r;
        logic [3:0] f;
        int t;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1 within 40 cycles", in_ready);
        end
        in_valid = 1'b1; op = o; acc_sel = s; operand = b;
        model(o, macc[s], b, r, f);
        macc[s] = r;
        e.sel = s; e.val = r; e.flg = f;
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for a done pulse, counting cycles with in_ready low.
    task automatic wait_done(output bit seen, output int not_ready);
        seen = 1'b0;
        not_ready = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (in_ready === 1'b0) not_ready++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; acc_sel = 2'd0; operand = 8'h00; rd_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) macc[i] = 8'h00;
        sb_q.delete();
        @(negedge clk);
        n_checks += 4;
        if (flags !== 4'h0)    begin n_fail++; $display("FAIL reset_flags: got %h required 0", flags); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++;
            if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_acc%0d: got %h required 00", i, rd_data); end
        end
    endtask

    // Issue a list of ops one at a time and check each completion.
    task automatic run_list(input string name, input logic [3:0] ops [], input logic [1:0] sels [],
                            input logic [7:0] bs []);
        bit seen;
        int nr;
        exp_t e;
        for (int i = 0; i < ops.size(); i++) begin
            send(ops[i], sels[i], bs[i]);
            wait_done(seen, nr);
            n_checks++;
            if (!seen || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_done%0d: done not seen (queue %0d)", name, i, sb_q.size());
            end else begin
                e = sb_q.pop_front();
                rd_sel = e.sel;
                #1;
                n_checks += 2;
                if (rd_data !== e.val) begin n_fail++; $display("FAIL %s_acc%0d: got %h required %h", name, i, rd_data, e.val); end
                if (flags !== e.flg)   begin n_fail++; $display("FAIL %s_flags%0d: got %b required %b", name, i, flags, e.flg); end
                if (ops[i] == 4'd12) begin
                    n_checks++;
                    if (nr != 8) begin n_fail++; $display("FAIL %s_busy_len: got %0d required 8", name, nr); end
                end
                @(negedge clk);
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL %s_pulse%0d: done=%b required 0", name, i, done); end
            end
        end
    endtask

    task automatic test_add_overflow();
        run_list("add", '{4'd9, 4'd2}, '{2'd0, 2'd0}, '{8'h7F, 8'h01});
    endtask

    task automatic test_sub_isolation();
        run_list("sub", '{4'd9, 4'd3}, '{2'd1, 2'd1}, '{8'h00, 8'h01});
        rd_sel = 2'd0;
        #1;
        n_checks++;
        if (rd_data !== macc[0]) begin n_fail++; $display("FAIL sub_other_acc: got %h required %h", rd_data, macc[0]); end
    endtask

    task automatic test_mul();
        run_list("mul", '{4'd9, 4'd12}, '{2'd2, 2'd2}, '{8'h0D, 8'h0B});
    endtask

    task automatic test_mul_busy_ignore();
        bit seen;
        int nr;
        int extra;
        exp_t e;
        run_list("mulz_ld", '{4'd9}, '{2'd3}, '{8'h10});
        send(4'd12, 2'd3, 8'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 4'd9; acc_sel = 2'd0; operand = 8'hAA;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(seen, nr);
        n_checks++;
        if (!seen || sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL mulz_done: done not seen (queue %0d)", sb_q.size());
        end else begin
            e = sb_q.pop_front();
            rd_sel = e.sel;
            #1;
            n_checks += 2;
            if (rd_data !== e.val) begin n_fail++; $display("FAIL mulz_acc: got %h required %h", rd_data, e.val); end
            if (flags !== e.flg)   begin n_fail++; $display("FAIL mulz_flags: got %b required %b", flags, e.flg); end
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        rd_sel = 2'd0;
        #1;
        n_checks += 2;
        if (extra != 0)          begin n_fail++; $display("FAIL busy_ignore_done: got %0d extra done required 0", extra); end
        if (rd_data !== macc[0]) begin n_fail++; $display("FAIL busy_ignore_acc0: got %h required %h", rd_data, macc[0]); end
    endtask

    task automatic test_mul_abort();
        int dones;
        run_list("abort_ld", '{4'd9}, '{2'd1}, '{8'h05});
        send(4'd12, 2'd1, 8'h03);
        void'(sb_q.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) macc[i] = 8'h00;
        n_checks += 3;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b required 1", in_ready); end
        if (flags !== 4'h0)    begin n_fail++; $display("FAIL abort_flags: got %h required 0", flags); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL abort_done: got %b required 0", done); end
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++;
            if (rd_data !== 8'h00) begin n_fail++; $display("FAIL abort_acc%0d: got %h required 00", i, rd_data); end
        end
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", dones); end
    endtask

    task automatic test_shift_reserved();
        run_list("shift", '{4'd9, 4'd10, 4'd9, 4'd11, 4'd13, 4'd15},
                 '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                 '{8'h81, 8'h00, 8'h81, 8'h00, 8'h55, 8'hFF});
    endtask

    // Accept a new op on every edge; each done cycle shows the previous result.
    task automatic test_back_to_back();
        logic [3:0] ops [12] = '{4'd9, 4'd2, 4'd7, 4'd4, 4'd8, 4'd6, 4'd5, 4'd3, 4'd1, 4'd0, 4'd9, 4'd10};
        logic [7:0] bs  [12] = '{8'h5A, 8'h33, 8'hFF, 8'h0F, 8'hC0, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h00};
        exp_t e;
        logic [7:0] r;
        logic [3:0] f;
        rd_sel = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; op = ops[i]; acc_sel = 2'd0; operand = bs[i];
            model(ops[i], macc[0], bs[i], r, f);
            macc[0] = r;
            e.sel = 2'd0; e.val = r; e.flg = f;
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_done%0d: done=%b required 1", i, done);
            end else begin
                e = sb_q.pop_front();
                n_checks += 2;
                if (rd_data !== e.val) begin n_fail++; $display("FAIL b2b_acc%0d: got %h required %h", i, rd_data, e.val); end
                if (flags !== e.flg)   begin n_fail++; $display("FAIL b2b_flags%0d: got %b required %b", i, flags, e.flg); end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_isolation();
        test_mul();
        test_mul_busy_ignore();
        test_mul_abort();
        test_shift_reserved();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left required 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
